if_fetch: RTL and testbench

- Instruction-fetch stage. Consumes the PC produced by the PC register and fetches a 32-bit instruction from the byte-wide memory controller as four sequential byte reads.
- Presents the assembled instruction and its PC to the IF/ID register.
- Raises a stall request while a fetch is in progress, so the PC register holds.
- Discards an in-progress fetch when ID signals a taken jump.

---
 rtl/if_fetch.sv | 128 ++++++++++++
 tb/tb_if_fetch.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch.sv
// Instruction fetch: four byte reads from pc..pc+3 assembled little-endian; if_valid 6 cycles after pc latch with back-to-back grants.
// Backpressure: waits on mem_grant with address held; holds output while stall[1]; jump_flag flushes to IDLE.
module if_fetch #(
    parameter int ADDR_LEN = 32,
    parameter int INST_LEN = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                chip_enable,
    input  logic [ADDR_LEN-1:0] pc,
    input  logic [5:0]          stall,
    input  logic                jump_flag,
    input  logic                mem_grant,
    input  logic [7:0]          mem_data,
    output logic                mem_req,
    output logic [ADDR_LEN-1:0] mem_addr,
    output logic [ADDR_LEN-1:0] if_pc,
    output logic [INST_LEN-1:0] if_inst,
    output logic                if_valid,
    output logic                stall_req
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        OUT   = 2'd2
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [ADDR_LEN-1:0]   fetch_pc;
    logic [2:0]            req_cnt;
    logic [2:0]            rcv_cnt;
    logic                  pend;
    logic [1:0]            pend_slot;
    logic [INST_LEN-9:0]   inst_buf;
    logic                  granted;
    logic                  start;
    logic                  last_byte;
    logic                  unused_stall;

    assign unused_stall = ^{stall[5:2], stall[0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        mem_req   = 1'b0;
        mem_addr  = '0;
        stall_req = 1'b0;
        if_valid  = 1'b0;
        start     = 1'b0;
        last_byte = 1'b0;
        case (state)
            IDLE: begin
                start = chip_enable && !jump_flag;
                if (start) begin
                    state_nxt = FETCH;
                end
            end
            FETCH: begin
                stall_req = 1'b1;
                mem_req   = (req_cnt < 3'd4);
                mem_addr  = fetch_pc + {{(ADDR_LEN-3){1'b0}}, req_cnt};
                // Bytes arrive in slot order, so the fourth arrival is slot 3.
                last_byte = pend && (rcv_cnt == 3'd3);
                if (jump_flag) begin
                    state_nxt = IDLE;
                end else if (last_byte) begin
                    state_nxt = OUT;
                end
            end
            OUT: begin
                if_valid = 1'b1;
                if (jump_flag || !stall[1]) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign granted = mem_req && mem_grant;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc  <= '0;
            req_cnt   <= '0;
            rcv_cnt   <= '0;
            pend      <= 1'b0;
            pend_slot <= '0;
            inst_buf  <= '0;
            if_pc     <= '0;
            if_inst   <= '0;
        end else begin
            // At most one byte is ever outstanding: data follows its grant by exactly one cycle.
            pend      <= granted;
            pend_slot <= req_cnt[1:0];
            if (start) begin
                fetch_pc <= pc;
                req_cnt  <= '0;
                rcv_cnt  <= '0;
            end else if (granted) begin
                req_cnt <= req_cnt + 3'd1;
            end
            if (state == FETCH && pend) begin
                rcv_cnt <= rcv_cnt + 3'd1;
                case (pend_slot)
                    2'd0:    inst_buf[7:0]   <= mem_data;
                    2'd1:    inst_buf[15:8]  <= mem_data;
                    2'd2:    inst_buf[23:16] <= mem_data;
                    default: ;
                endcase
            end
            if (last_byte && !jump_flag) begin
                if_inst <= {mem_data, inst_buf};
                if_pc   <= fetch_pc;
            end
        end
    end

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: byte-memory emulator, transaction-level reference model, directed and random phases.
module tb_if_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        chip_enable;
    logic [31:0] pc;
    logic [5:0]  stall;
    logic        jump_flag;
    logic        mem_grant;
    logic [7:0]  mem_data;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        if_valid;
    logic        stall_req;

    if_fetch #(.ADDR_LEN(32), .INST_LEN(32)) dut (
        .clk(clk), .rst(rst), .chip_enable(chip_enable), .pc(pc), .stall(stall),
        .jump_flag(jump_flag), .mem_grant(mem_grant), .mem_data(mem_data),
        .mem_req(mem_req), .mem_addr(mem_addr), .if_pc(if_pc), .if_inst(if_inst),
        .if_valid(if_valid), .stall_req(stall_req)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        logic [31:0] h;
        case (a)
            32'h100: mem_byte = 8'h13;
            32'h101: mem_byte = 8'h05;
            32'h102: mem_byte = 8'h10;
            32'h103: mem_byte = 8'h00;
            default: begin
                h = a * 32'h9E3779B1;
                mem_byte = h[31:24] ^ a[7:0];
            end
        endcase
    endfunction

    function automatic logic [31:0] word_at(input logic [31:0] p);
        word_at = {mem_byte(p + 32'd3), mem_byte(p + 32'd2), mem_byte(p + 32'd1), mem_byte(p)};
    endfunction

    // Reference: one fetch transaction at a time (0 idle, 1 fetching, 2 presenting).
    int          m_phase;
    logic [31:0] m_pc;
    int          m_granted;
    int          m_got;
    logic        m_pend;
    int          m_pslot;
    logic [31:0] m_word;
    logic [31:0] m_out_inst;
    logic [31:0] m_out_pc;
    // Memory emulator state and log of granted addresses.
    logic        e_pend;
    logic [31:0] e_addr;
    logic [31:0] gaddr_q[$];

    task automatic model_reset();
        m_phase = 0; m_granted = 0; m_got = 0; m_pend = 1'b0; m_pslot = 0;
        m_word = '0; m_out_inst = '0; m_out_pc = '0; e_pend = 1'b0; e_addr = '0;
    endtask

    task automatic compare_outputs();
        logic exp_req;
        exp_req = (m_phase == 1) && (m_granted < 4);
        check("mem_req", mem_req, exp_req);
        if (exp_req) check("mem_addr", mem_addr, m_pc + 32'(m_granted));
        check("stall_req", stall_req, m_phase == 1);
        check("if_valid", if_valid, m_phase == 2);
        if (m_phase == 2) begin
            check("if_inst", if_inst, m_out_inst);
            check("if_pc", if_pc, m_out_pc);
            check("inst_vs_mem", if_inst, word_at(if_pc));
        end
    endtask

    task automatic step(input logic ce, input logic [31:0] p, input logic jf,
                        input logic [5:0] st, input logic gnt);
        logic m_req;
        chip_enable = ce; pc = p; jump_flag = jf; stall = st; mem_grant = gnt;
        mem_data = e_pend ? mem_byte(e_addr) : 8'($urandom);
        if (mem_req && gnt) begin
            e_pend = 1'b1; e_addr = mem_addr; gaddr_q.push_back(mem_addr);
        end else begin
            e_pend = 1'b0;
        end
        m_req = (m_phase == 1) && (m_granted < 4);
        case (m_phase)
            0: if (ce && !jf) begin
                m_phase = 1; m_pc = p; m_granted = 0; m_got = 0; m_pend = 1'b0;
            end
            1: if (jf) begin
                m_phase = 0;
            end else begin
                if (m_pend) begin
                    m_word[8*m_pslot +: 8] = mem_data;
                    m_got++;
                    if (m_got == 4) begin
                        m_phase = 2; m_out_inst = m_word; m_out_pc = m_pc;
                    end
                end
                if (m_req && gnt) begin
                    m_pend = 1'b1; m_pslot = m_granted; m_granted++;
                end else begin
                    m_pend = 1'b0;
                end
            end
            default: if (jf || !st[1]) m_phase = 0;
        endcase
        @(posedge clk); #1;
        compare_outputs();
    endtask

    // One fetch from IDLE; gmode 0 = grant every cycle, 1 = grant on alternate cycles.
    task automatic run_fetch(input logic [31:0] p, input int gmode, output int lat,
                             output logic [31:0] inst, output logic [31:0] ipc, output int stall_cycles);
        lat = -1; inst = '0; ipc = '0; stall_cycles = 0;
        gaddr_q.delete();
        for (int i = 0; i < 24; i++) begin
            step(i == 0, p, 1'b0, 6'd0, (gmode == 0) ? 1'b1 : (i % 2 == 0));
            if (stall_req) stall_cycles++;
            if (if_valid && lat < 0) begin
                lat = i + 1; inst = if_inst; ipc = if_pc;
            end
        end
    endtask

    task automatic check_addrs(input string tag, input logic [31:0] base);
        check({tag, "_ngrants"}, gaddr_q.size(), 4);
        for (int k = 0; k < 4 && k < gaddr_q.size(); k++)
            check({tag, "_addr"}, gaddr_q[k], base + 32'(k));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, sc, vcnt, bad, outs;
        logic [31:0] inst, ipc, rp;
        logic [5:0]  st;

        rst = 1'b1; chip_enable = 1'b0; pc = '0; stall = '0; jump_flag = 1'b0;
        mem_grant = 1'b0; mem_data = '0;
        model_reset();
        #3;
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_if_pc", if_pc, 0);
        check("rst_if_inst", if_inst, 0);
        check("rst_if_valid", if_valid, 0);
        check("rst_stall_req", stall_req, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Back-to-back grants: minimum latency.
        run_fetch(32'h100, 0, lat, inst, ipc, sc);
        check("t1_latency", lat, 6);
        check("t1_inst", inst, 32'h00100513);
        check("t1_pc", ipc, 32'h100);
        check("t1_stall_cycles", sc, 5);
        check_addrs("t1", 32'h100);

        // Grant on alternate cycles: four cycles later, no byte duplicated or skipped.
        run_fetch(32'h100, 1, lat, inst, ipc, sc);
        check("t2_latency", lat, 10);
        check("t2_inst", inst, 32'h00100513);
        check_addrs("t2", 32'h100);

        // Address wrap.
        run_fetch(32'hFFFFFFFE, 0, lat, inst, ipc, sc);
        check("t3_inst", inst, word_at(32'hFFFFFFFE));
        check_addrs("t3", 32'hFFFFFFFE);

        // Flush after two bytes received, with a grant in the flush cycle.
        step(1'b1, 32'h200, 1'b0, 6'd0, 1'b1);
        step(1'b0, 32'h200, 1'b0, 6'd0, 1'b1);
        step(1'b0, 32'h200, 1'b0, 6'd0, 1'b1);
        step(1'b0, 32'h200, 1'b1, 6'd0, 1'b1);
        check("t4_mem_req", mem_req, 0);
        check("t4_stall_req", stall_req, 0);
        check("t4_if_valid", if_valid, 0);
        run_fetch(32'h300, 0, lat, inst, ipc, sc);
        check("t4_latency", lat, 6);
        check("t4_inst", inst, word_at(32'h300));
        check("t4_pc", ipc, 32'h300);
        check_addrs("t4", 32'h300);

        // stall[1] held three cycles in OUT.
        vcnt = 0; bad = 0;
        for (int i = 0; i < 14; i++) begin
            step(i == 0, 32'h400, 1'b0, (i >= 6 && i <= 8) ? 6'b000010 : 6'd0, 1'b1);
            if (if_valid) begin
                vcnt++;
                if (if_inst !== word_at(32'h400) || if_pc !== 32'h400) bad++;
            end
        end
        check("t5_valid_cycles", vcnt, 4);
        check("t5_unstable", bad, 0);
        check("t5_idle_after", if_valid, 0);

        // Asynchronous reset in the middle of a fetch.
        step(1'b1, 32'h500, 1'b0, 6'd0, 1'b1);
        step(1'b0, 32'h500, 1'b0, 6'd0, 1'b1);
        step(1'b0, 32'h500, 1'b0, 6'd0, 1'b1);
        #3 rst = 1'b1;
        #1;
        check("t6_mem_req", mem_req, 0);
        check("t6_mem_addr", mem_addr, 0);
        check("t6_stall_req", stall_req, 0);
        check("t6_if_valid", if_valid, 0);
        check("t6_if_pc", if_pc, 0);
        check("t6_if_inst", if_inst, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        run_fetch(32'h600, 0, lat, inst, ipc, sc);
        check("t6_latency", lat, 6);
        check("t6_inst", inst, word_at(32'h600));

        // Random traffic against the reference model.
        outs = 0;
        for (int i = 0; i < 800; i++) begin
            rp = ($urandom_range(0, 7) == 0) ? (32'hFFFFFFFC + 32'($urandom_range(0, 3))) : $urandom;
            st = 6'($urandom);
            st[1] = ($urandom_range(0, 2) == 0);
            step($urandom_range(0, 9) < 7, rp, $urandom_range(0, 24) == 0, st, $urandom_range(0, 9) < 6);
            if (if_valid) outs++;
        end
        check("rand_outputs_seen", outs > 20, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
